// File: rtl/mac_pkg.sv
// Shared defaults and pipeline control type for the multiply-accumulate datapath.
package mac_pkg;
  localparam int WIDTH_D       = 8;
  localparam int ACC_W_D       = 20;
  localparam int CNT_W_D       = 16;
  localparam int MULT_STAGES_D = 1;

  typedef struct packed {
    logic valid;
    logic clear;
  } pipe_ctl_t;
endpackage

// File: rtl/mac_valid_pipe.sv
// Shift register carrying valid/clear alongside the product stages; DEPTH = 0 is a wire.
module mac_valid_pipe
  import mac_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  pipe_ctl_t ctl_i,
  output pipe_ctl_t ctl_o
);

  pipe_ctl_t [DEPTH:0] vld_pipe;

  assign vld_pipe[0] = ctl_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    pipe_ctl_t ctl_q;
    always_ff @(posedge clk) begin
      if (reset) ctl_q <= '0;
      else       ctl_q <= vld_pipe[i];
    end
    assign vld_pipe[i+1] = ctl_q;
  end

  assign ctl_o = vld_pipe[DEPTH];

endmodule

// File: rtl/mac_acc_pipe.sv
// Pipelined unsigned multiply-accumulate with per-element clear, wrap/saturate
// overflow policy, sticky overflow flag and saturating sample counter.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH       = WIDTH_D,
  parameter int ACC_W       = ACC_W_D,
  parameter int MULT_STAGES = MULT_STAGES_D,
  parameter int SATURATE    = 0,
  parameter int CNT_W       = CNT_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             valid_in,
  input  logic             clear_acc,
  output logic [ACC_W-1:0] f,
  output logic             valid_out,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q, b_q;
  pipe_ctl_t        in_ctl_q, acc_ctl;

  // Operands and clear hold between valid elements; the valid bit always advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      in_ctl_q <= '0;
    end else begin
      in_ctl_q.valid <= valid_in;
      if (valid_in) begin
        a_q            <= a;
        b_q            <= b;
        in_ctl_q.clear <= clear_acc;
      end
    end
  end

  logic [MULT_STAGES:0][PW-1:0] prod_pipe;

  assign prod_pipe[0] = PW'(a_q) * PW'(b_q);

  for (genvar i = 0; i < MULT_STAGES; i++) begin : g_mul
    logic [PW-1:0] p_q;
    always_ff @(posedge clk) begin
      if (reset) p_q <= '0;
      else       p_q <= prod_pipe[i];
    end
    assign prod_pipe[i+1] = p_q;
  end

  mac_valid_pipe #(.DEPTH(MULT_STAGES)) u_vpipe (
    .clk   (clk),
    .reset (reset),
    .ctl_i (in_ctl_q),
    .ctl_o (acc_ctl)
  );

  logic [ACC_W-1:0] f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, vo_q;
  logic [ACC_W:0]   sum;

  // Extra sum bit is the carry that signals overflow.
  always_comb begin
    sum   = {1'b0, f_q} + (ACC_W+1)'(prod_pipe[MULT_STAGES]);
    f_d   = f_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (acc_ctl.valid) begin
      if (acc_ctl.clear) begin
        f_d   = ACC_W'(prod_pipe[MULT_STAGES]);
        ovf_d = 1'b0;
        cnt_d = CNT_W'(1);
      end else begin
        if (sum[ACC_W]) begin
          ovf_d = 1'b1;
          f_d   = (SATURATE != 0) ? '1 : sum[ACC_W-1:0];
        end else begin
          f_d   = sum[ACC_W-1:0];
        end
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      vo_q  <= 1'b0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      vo_q  <= acc_ctl.valid;
    end
  end

  assign f         = f_q;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign valid_out = vo_q;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed checks of mac_acc_pipe across five parameterisations sharing one stimulus bus.
module tb_mac_acc_pipe;

  logic       clk = 1'b0;
  logic       reset, va, clr;
  logic [7:0] a, b;

  logic [19:0] f_def, f_m0, f_m3;
  logic [15:0] f_w16, f_s16;
  logic [15:0] c_def, c_w16, c_s16, c_m0, c_m3;
  logic        vo_def, vo_w16, vo_s16, vo_m0, vo_m3;
  logic        ov_def, ov_w16, ov_s16, ov_m0, ov_m3;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.WIDTH(8), .ACC_W(20), .MULT_STAGES(1), .SATURATE(0), .CNT_W(16)) u_def (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(va), .clear_acc(clr),
    .f(f_def), .valid_out(vo_def), .overflow(ov_def), .count(c_def));
  mac_acc_pipe #(.WIDTH(8), .ACC_W(16), .MULT_STAGES(1), .SATURATE(0), .CNT_W(16)) u_w16 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(va), .clear_acc(clr),
    .f(f_w16), .valid_out(vo_w16), .overflow(ov_w16), .count(c_w16));
  mac_acc_pipe #(.WIDTH(8), .ACC_W(16), .MULT_STAGES(1), .SATURATE(1), .CNT_W(16)) u_s16 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(va), .clear_acc(clr),
    .f(f_s16), .valid_out(vo_s16), .overflow(ov_s16), .count(c_s16));
  mac_acc_pipe #(.WIDTH(8), .ACC_W(20), .MULT_STAGES(0), .SATURATE(0), .CNT_W(16)) u_m0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(va), .clear_acc(clr),
    .f(f_m0), .valid_out(vo_m0), .overflow(ov_m0), .count(c_m0));
  mac_acc_pipe #(.WIDTH(8), .ACC_W(20), .MULT_STAGES(3), .SATURATE(0), .CNT_W(16)) u_m3 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(va), .clear_acc(clr),
    .f(f_m3), .valid_out(vo_m3), .overflow(ov_m3), .count(c_m3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then land 1 time unit past the next rising edge.
  task automatic cyc(input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic c);
    va = v; a = aa; b = bb; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; va = 1'b0; clr = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f",   32'(f_def),  0);
    chk("rst_vo",  32'(vo_def), 0);
    chk("rst_ovf", 32'(ov_def), 0);
    chk("rst_cnt", 32'(c_def),  0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; va = 1'b0; clr = 1'b0; a = '0; b = '0;

    // Basic stream: squares 3,4,5 back to back.
    do_reset();
    cyc(1, 3, 3, 0); cyc(1, 4, 4, 0);
    chk("basic_vo_c2", 32'(vo_def), 0);
    cyc(1, 5, 5, 0);
    chk("basic_vo_c3", 32'(vo_def), 1);
    chk("basic_f_c3",  32'(f_def),  9);
    chk("basic_n_c3",  32'(c_def),  1);
    cyc(0, 0, 0, 0);
    chk("basic_vo_c4", 32'(vo_def), 1);
    chk("basic_f_c4",  32'(f_def),  25);
    chk("basic_n_c4",  32'(c_def),  2);
    cyc(0, 0, 0, 0);
    chk("basic_vo_c5", 32'(vo_def), 1);
    chk("basic_f_c5",  32'(f_def),  50);
    chk("basic_n_c5",  32'(c_def),  3);
    cyc(0, 0, 0, 0);
    chk("basic_vo_c6", 32'(vo_def), 0);
    chk("basic_f_c6",  32'(f_def),  50);

    // Bubbles reappear L cycles later.
    do_reset();
    cyc(1, 2, 2, 0); cyc(0, 9, 9, 0); cyc(1, 2, 2, 0);
    chk("bub_vo_c3", 32'(vo_def), 1);
    chk("bub_f_c3",  32'(f_def),  4);
    cyc(0, 0, 0, 0);
    chk("bub_vo_c4", 32'(vo_def), 0);
    chk("bub_f_c4",  32'(f_def),  4);
    cyc(0, 0, 0, 0);
    chk("bub_vo_c5", 32'(vo_def), 1);
    chk("bub_f_c5",  32'(f_def),  8);
    chk("bub_n_c5",  32'(c_def),  2);

    // Sum reaching exactly 2^20 wraps to 0 and sets overflow; clear mid-stream drops it.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 255, 255, 0);
    cyc(1, 112, 73, 0);
    cyc(1, 10, 10, 0);
    chk("clr_f_e15",   32'(f_def),  1040400);
    chk("clr_ovf_e15", 32'(ov_def), 0);
    chk("clr_n_e15",   32'(c_def),  16);
    cyc(1, 10, 10, 0);
    chk("clr_f_wrap",   32'(f_def),  0);
    chk("clr_ovf_wrap", 32'(ov_def), 1);
    chk("clr_n_wrap",   32'(c_def),  17);
    cyc(1, 1, 1, 1);
    chk("clr_f_e17",   32'(f_def),  100);
    chk("clr_ovf_e17", 32'(ov_def), 1);
    cyc(0, 0, 0, 0);
    chk("clr_f_e18",   32'(f_def),  200);
    chk("clr_ovf_e18", 32'(ov_def), 1);
    chk("clr_n_e18",   32'(c_def),  19);
    cyc(0, 0, 0, 0);
    chk("clr_f_e19",   32'(f_def),  1);
    chk("clr_ovf_e19", 32'(ov_def), 0);
    chk("clr_n_e19",   32'(c_def),  1);

    // 16-bit accumulator: wrap vs saturate.
    do_reset();
    cyc(1, 255, 255, 0); cyc(1, 255, 255, 0); cyc(0, 0, 0, 0);
    chk("ovw_f1",   32'(f_w16),  65025);
    chk("ovs_f1",   32'(f_s16),  65025);
    chk("ovw_ovf1", 32'(ov_w16), 0);
    cyc(0, 0, 0, 0);
    chk("ovw_f2",   32'(f_w16),  64514);
    chk("ovw_ovf2", 32'(ov_w16), 1);
    chk("ovs_f2",   32'(f_s16),  65535);
    chk("ovs_ovf2", 32'(ov_s16), 1);
    cyc(0, 0, 0, 0);
    chk("ovw_sticky", 32'(ov_w16), 1);
    chk("ovs_hold",   32'(f_s16),  65535);

    // Reset mid-stream discards in-flight elements and dominates valid_in.
    do_reset();
    cyc(1, 6, 6, 0); cyc(1, 7, 7, 0);
    reset = 1'b1;
    cyc(1, 8, 8, 0);
    chk("mrst_f",  32'(f_def),  0);
    chk("mrst_n",  32'(c_def),  0);
    chk("mrst_vo", 32'(vo_def), 0);
    cyc(1, 9, 9, 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      chk("mrst_vo_after", 32'(vo_def), 0);
      chk("mrst_f_after",  32'(f_def),  0);
    end

    // Latency sweep: L = 2 for MULT_STAGES=0, L = 5 for MULT_STAGES=3.
    do_reset();
    cyc(1, 7, 9, 0);
    for (int c = 1; c <= 6; c++) begin
      chk("lat0_vo", 32'(vo_m0), (c == 2) ? 1 : 0);
      chk("lat3_vo", 32'(vo_m3), (c == 5) ? 1 : 0);
      chk("lat0_f",  32'(f_m0),  (c >= 2) ? 63 : 0);
      chk("lat3_f",  32'(f_m3),  (c >= 5) ? 63 : 0);
      cyc(0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
